div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divider for DIV, DIVU, REM and REMU, sitting in the EX stage beside the ALU. It generates the `stall` request consumed by the hazard unit: it holds IF, ID and EX frozen while a divide is in flight, then releases the pipeline with the result valid. Multiplies are handled elsewhere and never reach this block.

## Interface
- No parameters; datapath width fixed at 32.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  EX stage holds a valid divide/remainder instruction.
- `funct3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are never presented with `start`.
- `op_a`  in  32  dividend (forwarded rs1).
- `op_b`  in  32  divisor (forwarded rs2).
- `flush`  in  1  synchronous abort: EX contents squashed.
- `stall`  out  1  to the hazard unit: freeze PC, IF/ID and ID/EX.
- `result`  out  32  quotient or remainder per `funct3`.
- `result_valid`  out  1  `result` is final this cycle; EX writes it back.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, `start`=1, `flush`=0:
  - Latch operands, `funct3`, signedness and the result sign.
  - Load the remainder register with 0, the quotient register with |dividend|, the divisor register with |divisor| (magnitudes for DIV/REM; raw values for DIVU/REMU).
  - Special case: go to DONE. Otherwise go to BUSY with counter = 0.
- BUSY, restoring division, one quotient bit per cycle:
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor, subtract the divisor and set the quotient LSB.
  - After the 32nd iteration (counter = 31), go to DONE.
- DONE: `result_valid`=1, `stall`=0. Go to IDLE next cycle. `start` is ignored in DONE because it is the same instruction.
- Sign fix-up is applied when the result is registered into DONE:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases, resolved with no iteration:
  - Divisor 0: q = 0xFFFFFFFF, r = op_a (all four ops).
  - DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF: q = 0x80000000, r = 0.
- `flush` in any state returns to IDLE next cycle. `stall` and `result_valid` are 0 in the flush cycle.

## Timing
- Reset values: state IDLE, counter 0, `stall` 0, `result_valid` 0, `result` 0, all datapath registers 0.
- `stall` is combinational: (IDLE & `start` & ~`flush` & ~cache hit) | BUSY.
- Normal divide: `stall` high for 33 cycles (IDLE cycle plus 32 BUSY), then DONE for 1 cycle. Total 34 cycles in EX.
- Special case: `stall` high for 1 cycle, then DONE. Total 2 cycles.
- `result` is registered and stable throughout DONE. It holds its last value in IDLE but is qualified only by `result_valid`.
- Reset asserted mid-BUSY: outputs return to reset values immediately (asynchronous). No partial result is ever flagged valid.
- Back-to-back divides: the second `start` is accepted in the IDLE cycle that follows DONE.

## Configuration
- `DIV_RESULT_REUSE_EN` defined: the block keeps the last completed quotient and remainder, plus op_a, op_b, signedness and a cache-valid bit.
  - In IDLE, `start` with equal op_a, op_b and signedness and cache-valid set is a hit.
  - On a hit, `result_valid`=1 and `stall`=0 in the same cycle, `result` is selected combinationally from the cache, and the state does not change.
  - Every DONE entry refills the cache; special cases also refill it.
  - Reset and `flush` during BUSY clear cache-valid.
  - Purpose: a DIV followed by a REM on the same operands costs no stall.
- `DIV_RESULT_REUSE_EN` undefined: no cache, no compare logic, and every divide takes the full latency.

## Test plan
- DIVU 100 / 7 → `stall` high exactly 33 cycles, then `result_valid` for 1 cycle with `result` = 14. REMU on the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → `result` = 0xFFFFFFFD. REM → 0xFFFFFFFF. DIV 7 / −2 → 0xFFFFFFFD. REM 7 / −2 → 1.
- DIVU 5 / 0 → `stall` high 1 cycle, `result` = 0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF → `stall` high 1 cycle, `result` = 0.
- Start DIV 1000 / 3, pull `rst_n` low at BUSY cycle 10 → `stall` and `result_valid` drop to 0 at once. After release, DIVU 9 / 3 gives 3 with normal latency.
- Start DIV, assert `flush` at BUSY cycle 5 → IDLE next cycle, no `result_valid`. The next `start` runs the full 33-cycle stall.
- With `DIV_RESULT_REUSE_EN`: DIV 17 / 5 (q = 3), then REM 17 / 5 → `result` = 2 in the `start` cycle with `stall` never asserted. Then REMU 17 / 6 → full 33-cycle stall, `result` = 5.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider (DIV/DIVU/REM/REMU) with pipeline stall request
//
// Restoring divider that sits in EX beside the ALU. A normal divide holds the
// pipeline for 33 cycles (accept cycle plus 32 iterations) and then presents
// the result for one DONE cycle. Divide-by-zero and signed overflow resolve
// without iterating.
//
// Optional feature: define DIV_RESULT_REUSE_EN to keep the last completed
// quotient/remainder pair so that a divide on identical operands and
// signedness (typically DIV followed by REM) completes in its start cycle.
//
// Ports:
//   clk           in   core clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   EX holds a valid divide/remainder instruction
//   funct3        in   100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a          in   dividend (forwarded rs1)
//   op_b          in   divisor (forwarded rs2)
//   flush         in   synchronous abort of EX contents
//   stall         out  freeze PC, IF/ID and ID/EX
//   result        out  quotient or remainder selected by funct3
//   result_valid  out  result is final this cycle

module div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] result,
   output logic        result_valid
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        is_rem_q;
   logic        q_neg_q;
   logic        r_neg_q;
   logic [31:0] result_q;

   // request decode; funct3[2] is set for every divide code
   logic        div_req;
   logic        is_signed;
   logic        is_rem;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic        div_zero, sgn_ovf, special;
   logic [31:0] spec_q, spec_r;
   logic        accept;
   logic        cache_hit;

   assign div_req   = start & funct3[2];
   assign is_signed = ~funct3[0];
   assign is_rem    = funct3[1];
   assign a_neg     = is_signed & op_a[31];
   assign b_neg     = is_signed & op_b[31];
   assign a_mag     = a_neg ? (32'd0 - op_a) : op_a;
   assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;
   assign div_zero  = (op_b == 32'd0);
   assign sgn_ovf   = is_signed & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
   assign special   = div_zero | sgn_ovf;
   assign spec_q    = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
   assign spec_r    = div_zero ? op_a : 32'd0;

   assign accept    = (state_q == IDLE) & div_req & ~flush & ~cache_hit;

   // one restoring step: shift {rem, quo} left, trial-subtract the divisor.
   // rem < divisor before the shift, so the shifted value needs 33 bits but
   // a successful difference always fits back into 32.
   logic [32:0] rem_sh;
   logic        ge;
   logic [31:0] diff;
   logic [31:0] rem_nx, quo_nx;
   logic [31:0] q_fix, r_fix;

   assign rem_sh = {rem_q, quo_q[31]};
   assign ge     = (rem_sh >= {1'b0, dvs_q});
   assign diff   = rem_sh[31:0] - dvs_q;
   assign rem_nx = ge ? diff : rem_sh[31:0];
   assign quo_nx = {quo_q[30:0], ge};
   assign q_fix  = q_neg_q ? (32'd0 - quo_nx) : quo_nx;
   assign r_fix  = r_neg_q ? (32'd0 - rem_nx) : rem_nx;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = special ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == 5'd31) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   // outputs
   always_comb begin
      stall        = 1'b0;
      result_valid = 1'b0;
      if (accept) begin
         stall = 1'b1;
      end
      if ((state_q == BUSY) && !flush) begin
         stall = 1'b1;
      end
      if (((state_q == DONE) || cache_hit) && !flush) begin
         result_valid = 1'b1;
      end
   end

   // datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 5'd0;
         rem_q    <= 32'd0;
         quo_q    <= 32'd0;
         dvs_q    <= 32'd0;
         is_rem_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  cnt_q    <= 5'd0;
                  rem_q    <= 32'd0;
                  quo_q    <= a_mag;
                  dvs_q    <= b_mag;
                  is_rem_q <= is_rem;
                  q_neg_q  <= a_neg ^ b_neg;
                  r_neg_q  <= a_neg;
                  if (special) begin
                     result_q <= is_rem ? spec_r : spec_q;
                  end
               end
            end
            BUSY: begin
               if (!flush) begin
                  rem_q <= rem_nx;
                  quo_q <= quo_nx;
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     result_q <= is_rem_q ? r_fix : q_fix;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef DIV_RESULT_REUSE_EN
   logic        cache_vld_q;
   logic        cache_sgn_q;
   logic [31:0] cache_a_q, cache_b_q;
   logic [31:0] cache_quo_q, cache_rem_q;
   logic [31:0] op_a_q, op_b_q;
   logic        sgn_q;
   logic [31:0] cache_res;

   assign cache_hit = (state_q == IDLE) & div_req & cache_vld_q &
                      (op_a == cache_a_q) & (op_b == cache_b_q) &
                      (is_signed == cache_sgn_q);
   assign cache_res = is_rem ? cache_rem_q : cache_quo_q;
   assign result    = cache_hit ? cache_res : result_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_vld_q <= 1'b0;
         cache_sgn_q <= 1'b0;
         cache_a_q   <= 32'd0;
         cache_b_q   <= 32'd0;
         cache_quo_q <= 32'd0;
         cache_rem_q <= 32'd0;
         op_a_q      <= 32'd0;
         op_b_q      <= 32'd0;
         sgn_q       <= 1'b0;
      end else if (accept) begin
         op_a_q <= op_a;
         op_b_q <= op_b;
         sgn_q  <= is_signed;
         if (special) begin
            cache_vld_q <= 1'b1;
            cache_sgn_q <= is_signed;
            cache_a_q   <= op_a;
            cache_b_q   <= op_b;
            cache_quo_q <= spec_q;
            cache_rem_q <= spec_r;
         end
      end else if (state_q == BUSY) begin
         if (flush) begin
            // an aborted divide leaves the cache in an unknown relation to EX
            cache_vld_q <= 1'b0;
         end else if (cnt_q == 5'd31) begin
            cache_vld_q <= 1'b1;
            cache_sgn_q <= sgn_q;
            cache_a_q   <= op_a_q;
            cache_b_q   <= op_b_q;
            cache_quo_q <= q_fix;
            cache_rem_q <= r_fix;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign result    = result_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking scoreboard bench for div_unit
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'b100;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        flush = 1'b0;
   logic        stall;
   logic [31:0] result;
   logic        result_valid;

   int errors = 0;
   int checks = 0;

   logic [31:0] sb_q[$];

   // reference model of the result cache (never hits unless the feature is built)
   bit          m_vld = 1'b0;
   logic [31:0] m_a = 32'd0;
   logic [31:0] m_b = 32'd0;
   bit          m_sgn = 1'b0;

   div_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .funct3       (funct3),
      .op_a         (op_a),
      .op_b         (op_b),
      .flush        (flush),
      .stall        (stall),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      bit sgn;
      bit rem;
      int sa;
      int sb;
      sgn = ~f3[0];
      rem = f3[1];
      if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
      if (sgn) begin
         sa = a;
         sb = b;
         return rem ? 32'(sa % sb) : 32'(sa / sb);
      end
      return rem ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic bit model_hit(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef DIV_RESULT_REUSE_EN
      return m_vld && (m_a == a) && (m_b == b) && (m_sgn == !f3[0]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
      int          n;
      bit          got;
      bit          hit;
      int          exp_stall;
      logic [31:0] e;
      hit       = model_hit(f3, a, b);
      exp_stall = hit ? 0 : (is_special(f3, a, b) ? 1 : 33);
      sb_q.push_back(exp);
      @(negedge clk);
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      n      = 0;
      got    = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         #1;
         if (result_valid === 1'b1) begin
            got = 1'b1;
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL %s result: got %h, scoreboard empty", name, result);
            end else begin
               e = sb_q.pop_front();
               if (result !== e) begin
                  errors++;
                  $display("FAIL %s result: got %h, expected %h", name, result, e);
               end
            end
         end else begin
            if (stall === 1'b1) n++;
            @(negedge clk);
         end
      end
      start = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: got no result_valid, expected one within 60 cycles", name);
         sb_q.delete();
      end
      checks++;
      if (n != exp_stall) begin
         errors++;
         $display("FAIL %s stall_cycles: got %0d, expected %0d", name, n, exp_stall);
      end
      if (got && !hit) begin
         m_vld = 1'b1;
         m_a   = a;
         m_b   = b;
         m_sgn = !f3[0];
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: got stall=%b valid=%b result=%h, expected 0 0 00000000",
                  stall, result_valid, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_unsigned;
      run_op(3'b101, 32'd100, 32'd7, 32'd14, "divu_100_7");
      @(negedge clk);
      #1;
      checks++;
      if (result_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL valid_one_cycle: got valid=%b stall=%b, expected 0 0", result_valid, stall);
      end
      run_op(3'b111, 32'd100, 32'd7, 32'd2, "remu_100_7");
   endtask

   task automatic test_signed;
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
      run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
      run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");
   endtask

   task automatic test_special;
      run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by_zero");
      run_op(3'b111, 32'd5, 32'd0, 32'd5, "remu_by_zero");
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      funct3 = 3'b100;
      op_a   = 32'd1000;
      op_b   = 32'd3;
      start  = 1'b1;
      repeat (11) @(negedge clk);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL busy_before_reset: got stall=%b, expected 1", stall);
      end
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: got stall=%b valid=%b result=%h, expected 0 0 00000000",
                  stall, result_valid, result);
      end
      m_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'b101, 32'd9, 32'd3, 32'd3, "divu_after_reset");
   endtask

   task automatic test_flush;
      int seen;
      @(negedge clk);
      funct3 = 3'b100;
      op_a   = 32'hFFFF_FF9C;
      op_b   = 32'd7;
      start  = 1'b1;
      repeat (6) @(negedge clk);
      flush = 1'b1;
      start = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_cycle: got stall=%b valid=%b, expected 0 0", stall, result_valid);
      end
      m_vld = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      seen  = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (result_valid === 1'b1 || stall === 1'b1) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_idle: got %0d active cycles, expected 0", seen);
      end
      run_op(3'b100, 32'd1000, 32'd3, 32'd333, "div_after_flush");
   endtask

   task automatic test_back_to_back;
      run_op(3'b101, 32'd200, 32'd9, 32'd22, "b2b_first");
      run_op(3'b100, 32'hFFFF_FFCE, 32'd7, 32'hFFFF_FFF9, "b2b_second");
   endtask

   task automatic test_reuse;
      run_op(3'b100, 32'd17, 32'd5, 32'd3, "reuse_div_17_5");
      run_op(3'b110, 32'd17, 32'd5, 32'd2, "reuse_rem_17_5");
      run_op(3'b111, 32'd17, 32'd6, 32'd5, "reuse_remu_17_6");
   endtask

   task automatic test_random;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 10; i++) begin
         f3 = 3'b100 | 3'($urandom_range(0, 3));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: b = $urandom;
         endcase
         run_op(f3, a, b, ref_res(f3, a, b), "random");
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_reset_mid();
      test_flush();
      test_back_to_back();
      test_reuse();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
